// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one ALU and one register file shared across
// FETCH/DECODE/EXEC/WB, instruction fetch over a req/ack handshake.
//
// state  | meaning
// IDLE   | waiting for start_i
// FETCH  | imem request outstanding, IR latched on ack
// DECODE | operand read, immediate sign-extension, opcode check
// EXEC   | ALU result, branch target and branch condition
// WB     | register write, PC update, retire pulse
// HALT   | stopped (halt or illegal opcode) until reset
module multicycle_cpu #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic            retire_o,
  output logic            halt_o,
  output logic            err_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);
  localparam int unsigned IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0]  NREG_W = 6'(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q;
  logic [31:0]     ir_q;
  logic            taken_q, err_q;
  logic [XLEN-1:0] regs_q [NREG];

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, dest;
  logic [XLEN-1:0] rs_val, rt_val, imm_sext, alu_res;
  logic            legal, wr_en;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{(XLEN-15){ir_q[15]}}, ir_q[14:0]};
  assign dest     = (opcode == OP_R) ? rd : rt;

  logic unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  // Index 0 and indices beyond NREG are hard-wired zero, read and write.
  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < NREG_W);
  endfunction

  always_comb begin
    rs_val     = '0;
    rt_val     = '0;
    dbg_data_o = '0;
    if (reg_ok(rs))         rs_val     = regs_q[rs[IW-1:0]];
    if (reg_ok(rt))         rt_val     = regs_q[rt[IW-1:0]];
    if (reg_ok(dbg_addr_i)) dbg_data_o = regs_q[dbg_addr_i[IW-1:0]];
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:            legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL};
      OP_ADDI, OP_BEQ: legal = 1'b1;
      default:         legal = 1'b0;
    endcase
  end

  // Shared ALU; for beq it produces the branch target.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD:  alu_res = a_q + b_q;
          FN_SUB:  alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = XLEN'($signed(a_q) < $signed(b_q));
          FN_MUL:  alu_res = a_q * b_q;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI: alu_res = a_q + imm_q;
      OP_BEQ:  alu_res = pc_q + XLEN'(4) + (imm_q << 2);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    retire_o   = 1'b0;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: state_d = (opcode == OP_HALT || !legal) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign wr_en       = (state_q == S_WB) && (opcode != OP_BEQ) && reg_ok(dest);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign halt_o      = (state_q == S_HALT);
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: if (imem_ack_i) ir_q <= imem_data_i;
        S_DECODE: begin
          a_q   <= rs_val;
          b_q   <= rt_val;
          imm_q <= imm_sext;
          if (opcode != OP_HALT && !legal) err_q <= 1'b1;
        end
        S_EXEC: begin
          alu_q   <= alu_res;
          taken_q <= (a_q == b_q);
        end
        S_WB: begin
          pc_q <= (opcode == OP_BEQ && taken_q) ? alu_q : pc_q + XLEN'(4);
          if (wr_en) regs_q[dest[IW-1:0]] <= alu_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a 32-bit core and a 16-bit/8-register
// core whose PC starts just below the wrap point, each fed by a wait-state imem.
`timescale 1ns/1ps
module tb_multicycle_cpu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [5:0]  F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                          F_OR = 6'h25, F_SLT = 6'h2A, F_MUL = 6'h18;

  logic        rst32 = 1'b1, start32 = 1'b0, req32, ack32, retire32, halt32, err32;
  logic [31:0] addr32, data32, pc32, dbgd32;
  logic [4:0]  dbga32 = 5'd0;

  logic        rst16 = 1'b1, start16 = 1'b0, req16, ack16, retire16, halt16, err16;
  logic [15:0] addr16, pc16, dbgd16;
  logic [31:0] data16;
  logic [4:0]  dbga16 = 5'd0;

  multicycle_cpu #(.XLEN(32), .NREG(32), .PC_RESET(32'h0)) dut32 (
    .clk_i(clk), .rst_i(rst32), .start_i(start32),
    .imem_req_o(req32), .imem_addr_o(addr32), .imem_ack_i(ack32), .imem_data_i(data32),
    .pc_o(pc32), .retire_o(retire32), .halt_o(halt32), .err_o(err32),
    .dbg_addr_i(dbga32), .dbg_data_o(dbgd32)
  );

  multicycle_cpu #(.XLEN(16), .NREG(8), .PC_RESET(16'hFFFC)) dut16 (
    .clk_i(clk), .rst_i(rst16), .start_i(start16),
    .imem_req_o(req16), .imem_addr_o(addr16), .imem_ack_i(ack16), .imem_data_i(data16),
    .pc_o(pc16), .retire_o(retire16), .halt_o(halt16), .err_o(err16),
    .dbg_addr_i(dbga16), .dbg_data_o(dbgd16)
  );

  // Instruction memories: ack after wait_cfg request cycles
  logic [31:0] mem32 [64];
  logic [31:0] mem16 [64];
  int   wait_cfg = 0;
  int   wcnt32 = 0, wcnt16 = 0;
  logic ack_force = 1'b0;

  assign ack32  = (req32 && (wcnt32 == wait_cfg)) || ack_force;
  assign ack16  = req16 && (wcnt16 == wait_cfg);
  assign data32 = mem32[addr32[7:2]];
  assign data16 = mem16[addr16[7:2]];

  logic unused_tb;
  assign unused_tb = ^{addr32[31:8], addr32[1:0], addr16[15:8], addr16[1:0]};

  always @(posedge clk) begin
    wcnt32 <= (req32 && !ack32) ? wcnt32 + 1 : 0;
    wcnt16 <= (req16 && !ack16) ? wcnt16 + 1 : 0;
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] rpc [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_addi(input logic [4:0] rt, input logic [4:0] rs,
                                         input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  function automatic logic [31:0] i_r(input logic [5:0] fn, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_beq(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {6'h04, rs, rt, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      mem32[i] = HALT_W;
      mem16[i] = HALT_W;
    end
  endtask

  task automatic do_reset(input bit sel);
    @(negedge clk);
    if (sel) rst16 = 1'b1; else rst32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (sel) rst16 = 1'b0; else rst32 = 1'b0;
  endtask

  // Returns #1 after the edge that samples start_i (cycle 0).
  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start16 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1;
    if (sel) start16 = 1'b0; else start32 = 1'b0;
  endtask

  task automatic run_to_halt(input bit sel, input int c0, input int maxc,
                             output int cycles, output int retires);
    cycles  = c0;
    retires = 0;
    rpc.delete();
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (sel ? retire16 : retire32) begin
        retires++;
        rpc.push_back(sel ? {16'h0, pc16} : pc32);
      end
      if (sel ? halt16 : halt32) break;
      if (cycles >= maxc) break;
    end
    check("halt_reached", {63'h0, (sel ? halt16 : halt32)}, 64'h1);
  endtask

  task automatic chk_reg(input bit sel, input logic [4:0] idx, input logic [31:0] exp,
                         input string tag);
    logic [31:0] v;
    if (sel) dbga16 = idx; else dbga32 = idx;
    #1;
    v = sel ? {16'h0, dbgd16} : dbgd32;
    check(tag, {32'h0, v}, {32'h0, exp});
  endtask

  int cyc, ret;

  initial begin
    clear_mem();
    do_reset(1'b0);
    do_reset(1'b1);
    #1;
    check("rst_pc32", pc32, 32'h0);
    check("rst_req32", req32, 1'b0);
    check("rst_halt32", halt32, 1'b0);
    check("rst_err32", err32, 1'b0);
    check("rst_retire32", retire32, 1'b0);
    check("rst_pc16", pc16, 16'hFFFC);
    chk_reg(1'b0, 5'd1, 32'h0, "rst_reg1");

    // Program A, zero-wait memory
    mem32[0] = i_addi(5'd1, 5'd0, 16'd5);
    mem32[1] = i_addi(5'd2, 5'd0, 16'hFFFD);
    mem32[2] = i_r(F_ADD, 5'd3, 5'd1, 5'd2);
    mem32[3] = HALT_W;
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 200, cyc, ret);
    check("a_cycles", cyc, 14);
    check("a_retires", ret, 3);
    check("a_err", err32, 1'b0);
    check("a_req_halted", req32, 1'b0);
    check("a_pc", pc32, 32'hC);
    chk_reg(1'b0, 5'd1, 32'h5, "a_r1");
    chk_reg(1'b0, 5'd2, 32'hFFFF_FFFD, "a_r2");
    chk_reg(1'b0, 5'd3, 32'h2, "a_r3");
    pulse_start(1'b0);
    @(posedge clk);
    #1;
    check("halt_ignores_start", halt32, 1'b1);
    check("halt_no_req", req32, 1'b0);

    // Program A with 3 wait cycles per fetch
    do_reset(1'b0);
    wait_cfg = 3;
    pulse_start(1'b0);
    check("w_req", req32, 1'b1);
    check("w_addr0", addr32, 32'h0);
    @(posedge clk);
    #1;
    check("w_addr1", addr32, 32'h0);
    @(posedge clk);
    #1;
    check("w_addr2", addr32, 32'h0);
    run_to_halt(1'b0, 2, 300, cyc, ret);
    check("w_cycles", cyc, 26);
    check("w_retires", ret, 3);
    chk_reg(1'b0, 5'd3, 32'h2, "w_r3");
    wait_cfg = 0;

    // Branches: taken 0x4 -> 0x10, not-taken 0x14 -> 0x18
    clear_mem();
    mem32[0] = i_addi(5'd1, 5'd0, 16'd7);
    mem32[1] = i_beq(5'd1, 5'd1, 16'd2);
    mem32[2] = i_addi(5'd5, 5'd0, 16'd1);
    mem32[3] = i_addi(5'd5, 5'd0, 16'd1);
    mem32[4] = i_addi(5'd2, 5'd0, 16'd9);
    mem32[5] = i_beq(5'd1, 5'd2, 16'd2);
    mem32[6] = HALT_W;
    mem32[7] = i_addi(5'd5, 5'd0, 16'd1);
    do_reset(1'b0);
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 200, cyc, ret);
    check("b_retires", ret, 4);
    check("b_taken_pc", rpc[2], 32'h10);
    check("b_nt_branch_pc", rpc[3], 32'h14);
    check("b_pc_final", pc32, 32'h18);
    chk_reg(1'b0, 5'd5, 32'h0, "b_skipped_r5");
    chk_reg(1'b0, 5'd2, 32'h9, "b_r2");

    // Arithmetic edge values
    clear_mem();
    mem32[0]  = i_addi(5'd1, 5'd0, 16'h4000);
    mem32[1]  = i_r(F_MUL, 5'd2, 5'd1, 5'd1);
    mem32[2]  = i_addi(5'd3, 5'd0, 16'd8);
    mem32[3]  = i_r(F_MUL, 5'd4, 5'd2, 5'd3);
    mem32[4]  = i_addi(5'd5, 5'd0, 16'd1);
    mem32[5]  = i_r(F_SUB, 5'd6, 5'd4, 5'd5);
    mem32[6]  = i_addi(5'd7, 5'd0, 16'hFFFF);
    mem32[7]  = i_r(F_SLT, 5'd8, 5'd7, 5'd5);
    mem32[8]  = i_r(F_SLT, 5'd9, 5'd5, 5'd7);
    mem32[9]  = i_addi(5'd10, 5'd0, 16'h0100);
    mem32[10] = i_r(F_MUL, 5'd11, 5'd10, 5'd10);
    mem32[11] = i_r(F_MUL, 5'd11, 5'd11, 5'd11);
    mem32[12] = i_r(F_ADD, 5'd0, 5'd5, 5'd5);
    mem32[13] = i_r(F_AND, 5'd13, 5'd6, 5'd4);
    mem32[14] = i_r(F_OR, 5'd14, 5'd6, 5'd4);
    mem32[15] = i_r(F_MUL, 5'd16, 5'd7, 5'd3);
    mem32[16] = HALT_W;
    do_reset(1'b0);
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 500, cyc, ret);
    check("c_cycles", cyc, 66);
    check("c_retires", ret, 16);
    chk_reg(1'b0, 5'd2, 32'h1000_0000, "c_mul_2p28");
    chk_reg(1'b0, 5'd4, 32'h8000_0000, "c_mul_2p31");
    chk_reg(1'b0, 5'd6, 32'h7FFF_FFFF, "c_sub_wrap");
    chk_reg(1'b0, 5'd8, 32'h1, "c_slt_m1_1");
    chk_reg(1'b0, 5'd9, 32'h0, "c_slt_1_m1");
    chk_reg(1'b0, 5'd10, 32'h100, "c_r10");
    chk_reg(1'b0, 5'd11, 32'h0, "c_mul_wrap");
    chk_reg(1'b0, 5'd0, 32'h0, "c_r0");
    chk_reg(1'b0, 5'd13, 32'h0, "c_and");
    chk_reg(1'b0, 5'd14, 32'hFFFF_FFFF, "c_or");
    chk_reg(1'b0, 5'd16, 32'hFFFF_FFF8, "c_mul_neg");

    // Illegal opcode 0x3E
    clear_mem();
    mem32[0] = i_addi(5'd1, 5'd0, 16'd3);
    mem32[1] = 32'hF800_0000;
    do_reset(1'b0);
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 200, cyc, ret);
    check("d_cycles", cyc, 6);
    check("d_retires", ret, 1);
    check("d_err", err32, 1'b1);
    check("d_pc", pc32, 32'h4);
    chk_reg(1'b0, 5'd1, 32'h3, "d_r1");

    // Unsupported R-type funct
    mem32[1] = i_r(6'h21, 5'd2, 5'd1, 5'd1);
    do_reset(1'b0);
    check("d2_err_cleared", err32, 1'b0);
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 200, cyc, ret);
    check("d2_err", err32, 1'b1);
    chk_reg(1'b0, 5'd2, 32'h0, "d2_r2");

    // Reset during a stalled fetch, then a stray ack while idle
    clear_mem();
    mem32[0] = i_addi(5'd1, 5'd0, 16'd5);
    mem32[1] = i_addi(5'd2, 5'd0, 16'hFFFD);
    mem32[2] = i_r(F_ADD, 5'd3, 5'd1, 5'd2);
    mem32[3] = HALT_W;
    do_reset(1'b0);
    pulse_start(1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk_reg(1'b0, 5'd2, 32'hFFFF_FFFD, "e_r2_before");
    wait_cfg = 10;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("e_fetching", req32, 1'b1);
    check("e_addr", addr32, 32'h8);
    @(negedge clk);
    rst32 = 1'b1;
    @(posedge clk);
    #1;
    check("e_req_after_rst", req32, 1'b0);
    check("e_pc_after_rst", pc32, 32'h0);
    check("e_halt_after_rst", halt32, 1'b0);
    @(negedge clk);
    rst32 = 1'b0;
    ack_force = 1'b1;
    @(posedge clk);
    #1;
    ack_force = 1'b0;
    check("e_late_ack_req", req32, 1'b0);
    check("e_late_ack_pc", pc32, 32'h0);
    chk_reg(1'b0, 5'd1, 32'h0, "e_r1_cleared");
    chk_reg(1'b0, 5'd2, 32'h0, "e_r2_cleared");
    wait_cfg = 0;
    pulse_start(1'b0);
    run_to_halt(1'b0, 0, 200, cyc, ret);
    check("e_rerun_cycles", cyc, 14);
    chk_reg(1'b0, 5'd3, 32'h2, "e_rerun_r3");

    // XLEN=16, NREG=8, PC starting at 0xFFFC
    mem16[63] = i_addi(5'd1, 5'd0, 16'h0011);
    mem16[0]  = i_addi(5'd9, 5'd0, 16'd5);
    mem16[1]  = i_addi(5'd3, 5'd0, 16'hFFFE);
    mem16[2]  = i_addi(5'd7, 5'd0, 16'd1);
    mem16[3]  = i_r(F_ADD, 5'd4, 5'd3, 5'd7);
    mem16[4]  = HALT_W;
    do_reset(1'b1);
    pulse_start(1'b1);
    run_to_halt(1'b1, 0, 200, cyc, ret);
    check("x_cycles", cyc, 22);
    check("x_retires", ret, 5);
    check("x_first_pc", rpc[0], 32'hFFFC);
    check("x_wrap_pc", rpc[1], 32'h0);
    check("x_pc_final", pc16, 16'h10);
    check("x_err", err16, 1'b0);
    chk_reg(1'b1, 5'd1, 32'h11, "x_r1");
    chk_reg(1'b1, 5'd9, 32'h0, "x_r9_oob");
    chk_reg(1'b1, 5'd3, 32'hFFFE, "x_r3");
    chk_reg(1'b1, 5'd7, 32'h1, "x_r7");
    chk_reg(1'b1, 5'd4, 32'hFFFF, "x_r4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
